// File: rtl/daq_pkg.sv
// Shared types and helpers for the entry-maker path: grant source codes,
// arbiter state encoding and saturating counter arithmetic.
package daq_pkg;

   localparam int CNT_W = 8;

   typedef enum logic [1:0] {
      SRC_MANUAL = 2'd0,
      SRC_AUTO   = 2'd1,
      SRC_A      = 2'd2,
      SRC_B      = 2'd3
   } src_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_BUSY  = 2'd2
   } st_e;

   // Adds 0..3 to a counter, sticking at all-ones.
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [1:0]       b);
      logic [CNT_W:0] s;
      s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
      return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
   endfunction

endpackage

// File: rtl/tpulse_sync.sv
// Two-flop synchronizer for an asynchronous pulse plus a registered
// rising-edge detector producing a one-cycle strobe.
module tpulse_sync (
   input  logic system_clock,
   input  logic resetn,
   input  logic pulse_i,
   output logic edge_o
);

   logic s1_q, s2_q, s3_q, edge_q;

   always_ff @(posedge system_clock or negedge resetn) begin
      if (!resetn) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         s3_q   <= 1'b0;
         edge_q <= 1'b0;
      end else begin
         s1_q   <= pulse_i;
         s2_q   <= s1_q;
         s3_q   <= s2_q;
         edge_q <= s2_q & ~s3_q;
      end
   end

   assign edge_o = edge_q;

endmodule

// File: rtl/entry_request_arbiter.sv
// Grants the entry builder one of four sources (manual, per-second auto,
// channel A/B sequences) with FIFO backpressure and a per-second sequence cap.
//
//   state    | meaning
//   ST_IDLE  | waiting for an eligible pending source with FIFO not almost full
//   ST_GRANT | one-cycle grant pulse, sequence ack issued
//   ST_BUSY  | waiting for build_done or the build timeout
module entry_request_arbiter
   import daq_pkg::*;
#(
   parameter int BUILD_TIMEOUT = 65536
) (
   input  logic             system_clock,
   input  logic             resetn,
   input  logic             t_pulse,
   input  logic             enable_auto,
   input  logic             enable_saving,
   input  logic [CNT_W-1:0] seq_limit,
   input  logic             entry_AmFull,
   input  logic             make_entry,
   input  logic             seq_req_A,
   input  logic             seq_req_B,
   output logic             seq_ack_A,
   output logic             seq_ack_B,
   output logic             seq_drop_A,
   output logic             seq_drop_B,
   output logic             grant_valid,
   output logic [1:0]       grant_src,
   input  logic             build_done,
   output logic             busy,
   output logic [CNT_W-1:0] seq_count,
   output logic [CNT_W-1:0] seq_last,
   output logic [CNT_W-1:0] drops_last,
   output logic             timeout_flag
);

   localparam int              TMO_W    = (BUILD_TIMEOUT > 2) ? $clog2(BUILD_TIMEOUT) : 1;
   localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(BUILD_TIMEOUT - 1);

   logic tp_edge;

   tpulse_sync u_tpulse_sync (
      .system_clock (system_clock),
      .resetn       (resetn),
      .pulse_i      (t_pulse),
      .edge_o       (tp_edge)
   );

   st_e              state_q;
   logic             pend_manual_q, pend_auto_q;
   logic             rr_b_q;
   logic             grant_valid_q, busy_q, timeout_flag_q;
   src_e             grant_src_q;
   logic             ack_a_q, ack_b_q, drop_a_q, drop_b_q;
   logic             ack_a_dly_q, ack_b_dly_q;
   logic [CNT_W-1:0] seq_count_q, drops_q, seq_last_q, drops_last_q;
   logic [TMO_W-1:0] tmo_q;

   logic req_a_v, req_b_v, seq_ok, drop_a, drop_b;
   logic gnt, gnt_a, gnt_b, gnt_man, gnt_auto;
   src_e gnt_src;
   logic [1:0] seq_inc, drop_inc;

   always_comb begin
      // A requester is still high while it sees its ack; mask it for two cycles.
      req_a_v = seq_req_A & ~ack_a_q & ~ack_a_dly_q;
      req_b_v = seq_req_B & ~ack_b_q & ~ack_b_dly_q;
      seq_ok  = enable_saving & ((seq_limit == '0) | (seq_count_q < seq_limit));
      drop_a  = req_a_v & ~seq_ok;
      drop_b  = req_b_v & ~seq_ok;
      gnt     = 1'b0;
      gnt_src = SRC_MANUAL;
      if ((state_q == ST_IDLE) && !entry_AmFull) begin
         if (pend_manual_q) begin
            gnt = 1'b1;
            gnt_src = SRC_MANUAL;
         end else if (pend_auto_q) begin
            gnt = 1'b1;
            gnt_src = SRC_AUTO;
         end else if (seq_ok && (req_a_v || req_b_v)) begin
            gnt = 1'b1;
            gnt_src = (req_a_v && (!rr_b_q || !req_b_v)) ? SRC_A : SRC_B;
         end
      end
      gnt_man  = gnt & (gnt_src == SRC_MANUAL);
      gnt_auto = gnt & (gnt_src == SRC_AUTO);
      gnt_a    = gnt & (gnt_src == SRC_A);
      gnt_b    = gnt & (gnt_src == SRC_B);
      seq_inc  = {1'b0, gnt_a | gnt_b};
      drop_inc = {1'b0, drop_a} + {1'b0, drop_b};
   end

   always_ff @(posedge system_clock or negedge resetn) begin
      if (!resetn) begin
         state_q        <= ST_IDLE;
         pend_manual_q  <= 1'b0;
         pend_auto_q    <= 1'b0;
         rr_b_q         <= 1'b0;
         grant_valid_q  <= 1'b0;
         grant_src_q    <= SRC_MANUAL;
         busy_q         <= 1'b0;
         timeout_flag_q <= 1'b0;
         ack_a_q        <= 1'b0;
         ack_b_q        <= 1'b0;
         drop_a_q       <= 1'b0;
         drop_b_q       <= 1'b0;
         ack_a_dly_q    <= 1'b0;
         ack_b_dly_q    <= 1'b0;
         seq_count_q    <= '0;
         drops_q        <= '0;
         seq_last_q     <= '0;
         drops_last_q   <= '0;
         tmo_q          <= '0;
      end else begin
         pend_manual_q <= (pend_manual_q & ~gnt_man) | make_entry;
         pend_auto_q   <= (pend_auto_q & ~gnt_auto) | (tp_edge & enable_auto);
         ack_a_q       <= gnt_a | drop_a;
         ack_b_q       <= gnt_b | drop_b;
         drop_a_q      <= drop_a;
         drop_b_q      <= drop_b;
         ack_a_dly_q   <= ack_a_q;
         ack_b_dly_q   <= ack_b_q;
         grant_valid_q <= gnt;
         if (gnt) grant_src_q <= gnt_src;
         if (gnt_a) rr_b_q <= 1'b1;
         if (gnt_b) rr_b_q <= 1'b0;

         // Same-cycle grants and drops belong to the second that is ending.
         if (tp_edge) begin
            seq_last_q   <= sat_add(seq_count_q, seq_inc);
            drops_last_q <= sat_add(drops_q, drop_inc);
            seq_count_q  <= '0;
            drops_q      <= '0;
         end else begin
            seq_count_q  <= sat_add(seq_count_q, seq_inc);
            drops_q      <= sat_add(drops_q, drop_inc);
         end

         case (state_q)
            ST_IDLE: begin
               if (gnt) begin
                  state_q <= ST_GRANT;
                  busy_q  <= 1'b1;
                  tmo_q   <= TMO_LOAD;
               end
            end
            ST_GRANT: begin
               state_q <= ST_BUSY;
               tmo_q   <= tmo_q - TMO_W'(1);
            end
            ST_BUSY: begin
               if (build_done) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else if (tmo_q == '0) begin
                  state_q        <= ST_IDLE;
                  busy_q         <= 1'b0;
                  timeout_flag_q <= 1'b1;
               end else begin
                  tmo_q <= tmo_q - TMO_W'(1);
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign seq_ack_A    = ack_a_q;
   assign seq_ack_B    = ack_b_q;
   assign seq_drop_A   = drop_a_q;
   assign seq_drop_B   = drop_b_q;
   assign grant_valid  = grant_valid_q;
   assign grant_src    = grant_src_q;
   assign busy         = busy_q;
   assign seq_count    = seq_count_q;
   assign seq_last     = seq_last_q;
   assign drops_last   = drops_last_q;
   assign timeout_flag = timeout_flag_q;

endmodule

// File: tb/tb_entry_request_arbiter.sv
// Directed bench for entry_request_arbiter: manual, round-robin, limit,
// backpressure, timeout, reset and rollover collision scenarios.
module tb_entry_request_arbiter;

   logic       system_clock = 1'b0;
   logic       resetn, t_pulse, enable_auto, enable_saving, entry_AmFull;
   logic       make_entry, seq_req_A, seq_req_B, build_done;
   logic [7:0] seq_limit;
   logic       seq_ack_A, seq_ack_B, seq_drop_A, seq_drop_B;
   logic       grant_valid, busy, timeout_flag;
   logic [1:0] grant_src;
   logic [7:0] seq_count, seq_last, drops_last;

   int total = 0;
   int bad   = 0;

   always #5 system_clock = ~system_clock;

   entry_request_arbiter #(.BUILD_TIMEOUT(16)) dut (
      .system_clock (system_clock),
      .resetn       (resetn),
      .t_pulse      (t_pulse),
      .enable_auto  (enable_auto),
      .enable_saving(enable_saving),
      .seq_limit    (seq_limit),
      .entry_AmFull (entry_AmFull),
      .make_entry   (make_entry),
      .seq_req_A    (seq_req_A),
      .seq_req_B    (seq_req_B),
      .seq_ack_A    (seq_ack_A),
      .seq_ack_B    (seq_ack_B),
      .seq_drop_A   (seq_drop_A),
      .seq_drop_B   (seq_drop_B),
      .grant_valid  (grant_valid),
      .grant_src    (grant_src),
      .build_done   (build_done),
      .busy         (busy),
      .seq_count    (seq_count),
      .seq_last     (seq_last),
      .drops_last   (drops_last),
      .timeout_flag (timeout_flag)
   );

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge system_clock);
      #1;
   endtask

   initial begin
      resetn = 1'b0; t_pulse = 1'b0; enable_auto = 1'b0; enable_saving = 1'b1;
      entry_AmFull = 1'b0; make_entry = 1'b0; seq_req_A = 1'b0; seq_req_B = 1'b0;
      build_done = 1'b0; seq_limit = 8'd0;
      repeat (3) tick();
      chk1("rst_gv", grant_valid, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk2("rst_src", grant_src, 2'd0);
      chk8("rst_cnt", seq_count, 8'd0);
      chk1("rst_tmo", timeout_flag, 1'b0);
      resetn = 1'b1;
      tick();

      // manual request: grant two cycles after the pulse, release on build_done
      make_entry = 1'b1;
      tick();
      make_entry = 1'b0;
      chk1("man_early", grant_valid, 1'b0);
      tick();
      chk1("man_gv", grant_valid, 1'b1);
      chk2("man_src", grant_src, 2'd0);
      chk1("man_busy", busy, 1'b1);
      repeat (8) tick();
      chk1("man_busy_hold", busy, 1'b1);
      chk1("man_gv_pulse", grant_valid, 1'b0);
      build_done = 1'b1;
      tick();
      build_done = 1'b0;
      chk1("man_release", busy, 1'b0);

      // round robin A, B, A
      seq_req_A = 1'b1; seq_req_B = 1'b1;
      tick();
      chk1("rr1_gv", grant_valid, 1'b1);
      chk2("rr1_src", grant_src, 2'd2);
      chk1("rr1_ackA", seq_ack_A, 1'b1);
      chk1("rr1_dropA", seq_drop_A, 1'b0);
      chk1("rr1_ackB", seq_ack_B, 1'b0);
      chk8("rr1_cnt", seq_count, 8'd1);
      tick();
      chk1("rr1_ack_pulse", seq_ack_A, 1'b0);
      seq_req_A = 1'b0; build_done = 1'b1;
      tick();
      build_done = 1'b0;
      tick();
      chk1("rr2_gv", grant_valid, 1'b1);
      chk2("rr2_src", grant_src, 2'd3);
      chk1("rr2_ackB", seq_ack_B, 1'b1);
      chk1("rr2_dropB", seq_drop_B, 1'b0);
      chk8("rr2_cnt", seq_count, 8'd2);
      seq_req_A = 1'b1;
      tick();
      chk1("rr2_gv_pulse", grant_valid, 1'b0);
      seq_req_B = 1'b0; build_done = 1'b1;
      tick();
      build_done = 1'b0;
      tick();
      chk2("rr3_src", grant_src, 2'd2);
      chk8("rr3_cnt", seq_count, 8'd3);
      tick();
      seq_req_A = 1'b0; build_done = 1'b1;
      tick();
      build_done = 1'b0;

      // rollover timing: tp_edge acts on the fourth edge after t_pulse rises
      t_pulse = 1'b1;
      repeat (3) tick();
      chk8("tp_not_early", seq_count, 8'd3);
      tick();
      chk8("tp1_cnt", seq_count, 8'd0);
      chk8("tp1_last", seq_last, 8'd3);
      chk8("tp1_drops", drops_last, 8'd0);
      t_pulse = 1'b0;

      // limit of three: five A requests give three grants and two drops
      seq_limit = 8'd3;
      for (int i = 0; i < 5; i++) begin
         seq_req_A = 1'b1;
         tick();
         chk1("lim_ack", seq_ack_A, 1'b1);
         chk1("lim_drop", seq_drop_A, (i >= 3));
         chk1("lim_gv", grant_valid, (i < 3));
         chk8("lim_cnt", seq_count, (i < 3) ? 8'(i + 1) : 8'd3);
         tick();
         seq_req_A = 1'b0;
         build_done = (i < 3);
         tick();
         build_done = 1'b0;
      end
      t_pulse = 1'b1;
      repeat (4) tick();
      chk8("lim_last", seq_last, 8'd3);
      chk8("lim_drops", drops_last, 8'd2);
      chk8("lim_cnt_clr", seq_count, 8'd0);
      t_pulse = 1'b0;
      seq_limit = 8'd0;

      // backpressure with manual and auto both pending
      entry_AmFull = 1'b1; enable_auto = 1'b1; make_entry = 1'b1;
      tick();
      make_entry = 1'b0; t_pulse = 1'b1;
      repeat (4) tick();
      chk1("bp_no_gv", grant_valid, 1'b0);
      tick();
      chk1("bp_no_busy", busy, 1'b0);
      chk8("bp_last", seq_last, 8'd0);
      chk8("bp_drops", drops_last, 8'd0);
      entry_AmFull = 1'b0; t_pulse = 1'b0;
      tick();
      chk1("bp_man_gv", grant_valid, 1'b1);
      chk2("bp_man_src", grant_src, 2'd0);
      tick();
      entry_AmFull = 1'b1;
      tick();
      chk1("bp_full_in_busy", busy, 1'b1);
      build_done = 1'b1; entry_AmFull = 1'b0;
      tick();
      build_done = 1'b0;
      chk1("bp_idle", busy, 1'b0);
      tick();
      chk1("bp_auto_gv", grant_valid, 1'b1);
      chk2("bp_auto_src", grant_src, 2'd1);
      tick();
      build_done = 1'b1;
      tick();
      build_done = 1'b0; enable_auto = 1'b0;

      // build timeout of 16 cycles
      make_entry = 1'b1;
      tick();
      make_entry = 1'b0;
      tick();
      chk1("to_gv", grant_valid, 1'b1);
      repeat (15) tick();
      chk1("to_busy", busy, 1'b1);
      chk1("to_flag_early", timeout_flag, 1'b0);
      tick();
      chk1("to_release", busy, 1'b0);
      chk1("to_flag", timeout_flag, 1'b1);

      // asynchronous reset during BUSY
      seq_req_A = 1'b1;
      tick();
      chk2("rs_src", grant_src, 2'd2);
      chk8("rs_cnt_pre", seq_count, 8'd1);
      tick();
      seq_req_A = 1'b0;
      #2 resetn = 1'b0;
      #1;
      chk1("rs_busy", busy, 1'b0);
      chk2("rs_src0", grant_src, 2'd0);
      chk8("rs_cnt", seq_count, 8'd0);
      chk1("rs_flag", timeout_flag, 1'b0);
      chk8("rs_last", seq_last, 8'd0);
      tick();
      resetn = 1'b1;

      // tp_edge coincident with a B grant
      seq_req_A = 1'b1;
      tick();
      tick();
      seq_req_A = 1'b0; build_done = 1'b1;
      tick();
      build_done = 1'b0; t_pulse = 1'b1;
      repeat (3) tick();
      chk8("col_cnt_pre", seq_count, 8'd1);
      seq_req_B = 1'b1;
      tick();
      chk1("col_gv", grant_valid, 1'b1);
      chk2("col_src", grant_src, 2'd3);
      chk1("col_ackB", seq_ack_B, 1'b1);
      chk8("col_last", seq_last, 8'd2);
      chk8("col_cnt", seq_count, 8'd0);
      tick();
      seq_req_B = 1'b0; build_done = 1'b1;
      tick();
      build_done = 1'b0; t_pulse = 1'b0;

      // saving disabled: request dropped without a grant
      enable_saving = 1'b0;
      seq_req_A = 1'b1;
      tick();
      chk1("dis_ack", seq_ack_A, 1'b1);
      chk1("dis_drop", seq_drop_A, 1'b1);
      chk1("dis_gv", grant_valid, 1'b0);
      tick();
      seq_req_A = 1'b0;
      tick();
      chk8("dis_cnt", seq_count, 8'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
